// File: rtl/serial_pkg.sv
// serial_pkg
// Shared definitions for the serial line transmitter and the detector /
// receiver FSMs that sample the same line.
//   - Frame FSM state encodings (3-bit): IDLE, START, DATA, PARITY, STOP
//   - IDLE_LEVEL: level of the line between frames
//   - calc_parity(): parity bit of a word (up to 16 bits)
package serial_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic IDLE_LEVEL = 1'b1;

  // Callers zero-extend narrower words. Extra zero bits do not change the XOR.
  function automatic logic calc_parity(input logic [15:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// bit_timer
// Counts clocks within one bit period. It pulses bit_end on the last clock
// of the period and then wraps to zero.
// Ports:
//   clk     in   clock, rising edge
//   reset_n in   asynchronous active-low reset
//   clear   in   force the count to zero (held while the transmitter idles)
//   enable  in   advance the count
//   bit_end out  high during the final clock of a bit period
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  // The pulse is combinational from the registered count. The FSM therefore
  // sees it on the same edge at which the count wraps, so every period is
  // exactly CLKS_PER_BIT clocks long.
  assign bit_end = enable && !clear && (count == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
// Accepts a parallel word through a valid/ready handshake and sends it as a
// frame: start bit (0), DATA_W data bits LSB first, an optional parity bit,
// and a stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   tx_valid  in   tx_data holds a word to send
//   tx_data   in   word to send (DATA_W bits)
//   tx_ready  out  idle and able to accept a word
//   tx_serial out  registered serial line (idles high)
//   tx_busy   out  frame in progress
//   tx_done   out  one-clock pulse when a frame completes
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  logic [2:0]        state;
  logic [DATA_W-1:0] shift_reg;
  logic [BW-1:0]     bit_count;
  logic              parity_bit;
  logic              bit_end;

  // While idle, the timer is held at zero. The accepting edge therefore
  // starts the start bit with a fresh count. Every other state change
  // happens on bit_end, when the count wraps to zero by itself.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state == IDLE),
    .enable (state != IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_count  <= '0;
      parity_bit <= 1'b0;
      tx_serial  <= IDLE_LEVEL;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            shift_reg  <= tx_data;
            parity_bit <= calc_parity(16'(tx_data), PARITY_ODD != 0);
            bit_count  <= '0;
            tx_serial  <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          // Present bit 0 and shift, so shift_reg[0] always holds the next bit.
          if (bit_end) begin
            tx_serial <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_count <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_count == LAST_BIT) begin
              bit_count <= '0;
              if (PARITY_EN != 0) begin
                tx_serial <= parity_bit;
                state     <= PARITY;
              end else begin
                tx_serial <= IDLE_LEVEL;
                state     <= STOP;
              end
            end else begin
              bit_count <= bit_count + BW'(1);
              tx_serial <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx_serial <= IDLE_LEVEL;
            state     <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            tx_done <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          tx_serial <= IDLE_LEVEL;
          state     <= IDLE;
        end
      endcase
    end
  end

  // ready follows the state register directly, so an asynchronous reset
  // raises it immediately.
  assign tx_ready = (state == IDLE);
  assign tx_busy  = !tx_ready;

endmodule
